// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between the decoder/mux (master side) and the SRAM slave.
interface ahb_sram_slave_if #(
   parameter int ADDR_W = 32
);
   logic              hsel;
   logic [ADDR_W-1:0] haddr;
   logic [1:0]        htrans;
   logic              hwrite;
   logic [2:0]        hsize;
   logic [2:0]        hburst;
   logic [31:0]       hwdata;
   logic              hready;
   logic [31:0]       hrdata;
   logic              hreadyout;
   logic              hresp;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
      input  hrdata, hreadyout, hresp
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
      output hrdata, hreadyout, hresp
   );
endinterface

// File: rtl/ahb_sram_slave.sv
// Parametrised AHB-Lite SRAM slave: byte-lane writes, zero-latency reads, two-cycle ERROR.
// Optional wait states with `define AHB_SLV_WAIT_EN (WAIT_CYCLES per legal transfer).
module ahb_sram_slave #(
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 0
) (
   input  logic            hclk,
   input  logic            hreset,
   ahb_sram_slave_if.slave bus
);
   localparam int              IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH * 4);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
`ifdef AHB_SLV_WAIT_EN
      ST_WAIT,
`endif
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t           state;
   logic             ready_q, resp_q;
   logic [IDX_W-1:0] d_idx;
   logic [3:0]       d_be;
   logic             d_write;
`ifdef AHB_SLV_WAIT_EN
   logic [3:0]       wcnt;
`endif

   logic [3:0][7:0]  mem [DEPTH];

   logic             cap, illegal;
   logic [3:0]       be;
   logic             unused_bits;

   assign cap = bus.hsel & bus.hready & bus.htrans[1];

   always_comb begin
      illegal = ({1'b0, bus.haddr} >= LIMIT) ||
                (bus.hsize > 3'b010) ||
                (bus.hsize == 3'b001 && bus.haddr[0]) ||
                (bus.hsize == 3'b010 && bus.haddr[1:0] != 2'b00);
      case (bus.hsize)
         3'b000:  be = 4'b0001 << bus.haddr[1:0];
         3'b001:  be = bus.haddr[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state   <= ST_IDLE;
         ready_q <= 1'b1;
         resp_q  <= 1'b0;
         d_idx   <= '0;
         d_be    <= '0;
         d_write <= 1'b0;
`ifdef AHB_SLV_WAIT_EN
         wcnt    <= '0;
`endif
      end else begin
         case (state)
`ifdef AHB_SLV_WAIT_EN
            ST_WAIT: begin
               if (wcnt == 4'd0) begin
                  state   <= ST_DATA;
                  ready_q <= 1'b1;
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end
`endif
            ST_ERR1: begin
               state   <= ST_ERR2;
               ready_q <= 1'b1;
               resp_q  <= 1'b1;
            end
            // IDLE, DATA and ERR2 all accept a new address phase
            default: begin
               if (cap) begin
                  d_idx   <= bus.haddr[IDX_W+1:2];
                  d_be    <= be;
                  d_write <= bus.hwrite & ~illegal;
                  if (illegal) begin
                     state   <= ST_ERR1;
                     ready_q <= 1'b0;
                     resp_q  <= 1'b1;
                  end
`ifdef AHB_SLV_WAIT_EN
                  else if (WAIT_CYCLES > 0) begin
                     state   <= ST_WAIT;
                     ready_q <= 1'b0;
                     resp_q  <= 1'b0;
                     wcnt    <= 4'(WAIT_CYCLES - 1);
                  end
`endif
                  else begin
                     state   <= ST_DATA;
                     ready_q <= 1'b1;
                     resp_q  <= 1'b0;
                  end
               end else begin
                  state   <= ST_IDLE;
                  ready_q <= 1'b1;
                  resp_q  <= 1'b0;
                  d_write <= 1'b0;
               end
            end
         endcase
      end
   end

   // Write lands at the edge closing DATA, so a following read's data phase sees it.
   always_ff @(posedge hclk) begin
      if (!hreset && state == ST_DATA && d_write) begin
         for (int l = 0; l < 4; l++) begin
            if (d_be[l]) mem[d_idx][l] <= bus.hwdata[8*l +: 8];
         end
      end
   end

   assign bus.hrdata    = (state == ST_DATA) ? mem[d_idx] : 32'h0;
   assign bus.hreadyout = ready_q;
   assign bus.hresp     = resp_q;

   assign unused_bits = ^{bus.hburst, bus.htrans[0], 4'(WAIT_CYCLES)};
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomized scoreboard bench for ahb_sram_slave; byte-array reference model.
// Build with +define+AHB_SLV_WAIT_EN to exercise two wait states and reset mid-wait.
module tb_ahb_sram_slave;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 256;
`ifdef AHB_SLV_WAIT_EN
   localparam int WAITS  = 2;
`else
   localparam int WAITS  = 0;
`endif

   logic hclk   = 1'b0;
   logic hreset = 1'b1;

   ahb_sram_slave_if #(.ADDR_W(ADDR_W)) bus ();

   ahb_sram_slave #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
      .hclk  (hclk),
      .hreset(hreset),
      .bus   (bus)
   );

   always #5 hclk = ~hclk;
   assign bus.hready = bus.hreadyout;

   typedef struct {
      logic        err;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   logic [7:0]  model_mem [DEPTH*4];

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: actual %h required %h", name, act, req);
   endtask

   function automatic bit legal(input logic [31:0] a, input logic [2:0] sz);
      return (a < DEPTH * 4) && (sz <= 3'd2) && !(sz == 3'd1 && a[0]) && !(sz == 3'd2 && a[1:0] != 2'b00);
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] a);
      logic [31:0] base = {a[31:2], 2'b00};
      return {model_mem[base+3], model_mem[base+2], model_mem[base+1], model_mem[base]};
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
      int nbytes = 1 << sz;
      logic [31:0] base = a & ~(32'(nbytes) - 32'd1);
      for (int i = 0; i < nbytes; i++) begin
         logic [31:0] b = base + 32'(i);
         model_mem[b] = wd[8*b[1:0] +: 8];
      end
   endtask

   // One AHB address phase; push the expected response once the slave accepts it.
   task automatic xfer(input bit sel, input logic [1:0] tr, input logic [31:0] a, input bit w,
                       input logic [2:0] sz, input logic [31:0] wd, input bit upd = 1'b1);
      int   guard = 0;
      exp_t e;
      bus.hsel   = sel;
      bus.htrans = tr;
      bus.haddr  = a;
      bus.hwrite = w;
      bus.hsize  = sz;
      bus.hburst = 3'b001;
      while (!bus.hreadyout && guard < 40) begin
         @(posedge hclk); #1;
         guard++;
      end
      if (guard >= 40) chk(1'b0, "hready_timeout", 32'(bus.hreadyout), 32'd1);
      @(posedge hclk); #1;
      if (sel && tr[1]) begin
         e.err  = !legal(a, sz);
         e.wr   = w;
         e.addr = a;
         e.data = 32'h0;
         if (w) begin
            bus.hwdata = wd;
            if (!e.err && upd) model_write(a, sz, wd);
         end else if (!e.err) begin
            e.data = model_word(a);
         end
         sb.push_back(e);
      end
   endtask

   task automatic idle_bus();
      xfer(1'b0, 2'b00, 32'h0, 1'b0, 3'b010, 32'h0);
   endtask

   // Monitor: tracks data phases from bus activity alone and scores each completion.
   logic phase = 1'b0, acc_last = 1'b0, rdy_last = 1'b0, rst_last = 1'b1;
   logic saw_resp = 1'b0, bad_wait = 1'b0;
   int   waitcnt = 0;

   always @(negedge hclk) begin
      exp_t e;
      bit   ok;
      if (rst_last) begin
         phase = 1'b0;
         sb.delete();
         waitcnt = 0; saw_resp = 1'b0; bad_wait = 1'b0;
      end else if (rdy_last) begin
         phase = acc_last;
      end
      if (!hreset) begin
         if (!phase) begin
            chk(bus.hreadyout && !bus.hresp && bus.hrdata == 32'h0, "idle_okay",
                {bus.hrdata[29:0], bus.hreadyout, bus.hresp}, 32'h2);
         end else if (!bus.hreadyout) begin
            waitcnt++;
            saw_resp = saw_resp | bus.hresp;
            bad_wait = bad_wait | (bus.hrdata != 32'h0);
            if (waitcnt > 20) begin
               chk(1'b0, "stall", 32'(waitcnt), 32'(WAITS));
               phase = 1'b0; waitcnt = 0;
            end
         end else if (sb.size() == 0) begin
            chk(1'b0, "unexpected_resp", bus.hrdata, 32'h0);
            waitcnt = 0; saw_resp = 1'b0; bad_wait = 1'b0;
         end else begin
            e = sb.pop_front();
            if (e.err) begin
               ok = waitcnt == 1 && saw_resp && bus.hresp && !bad_wait && bus.hrdata == 32'h0;
               if (!ok) $display("FAIL err_resp addr=%h: waits=%0d err1=%b hresp=%b hrdata=%h, want waits=1 err1=1 hresp=1 hrdata=0",
                                 e.addr, waitcnt, saw_resp, bus.hresp, bus.hrdata);
            end else begin
               ok = waitcnt == WAITS && !saw_resp && !bus.hresp && !bad_wait && (e.wr || bus.hrdata == e.data);
               if (!ok) $display("FAIL %s addr=%h: waits=%0d hresp=%b hrdata=%h, want waits=%0d hresp=0 hrdata=%h",
                                 e.wr ? "write_okay" : "read_data", e.addr, waitcnt, bus.hresp, bus.hrdata,
                                 WAITS, e.data);
            end
            n_chk++;
            if (ok) n_pass++;
            waitcnt = 0; saw_resp = 1'b0; bad_wait = 1'b0;
         end
      end
      acc_last = bus.hsel & bus.htrans[1] & bus.hreadyout;
      rdy_last = bus.hreadyout;
      rst_last = hreset;
   end

   initial begin
      int guard;
      bus.hsel = 1'b0; bus.htrans = 2'b00; bus.haddr = '0; bus.hwrite = 1'b0;
      bus.hsize = 3'b010; bus.hburst = 3'b000; bus.hwdata = '0;
      hreset = 1'b1;
      repeat (2) @(posedge hclk);
      #1;
      chk(bus.hreadyout == 1'b1, "reset_hreadyout", 32'(bus.hreadyout), 32'd1);
      chk(bus.hresp == 1'b0,     "reset_hresp",     32'(bus.hresp),     32'd0);
      chk(bus.hrdata == 32'h0,   "reset_hrdata",    bus.hrdata,         32'h0);
      hreset = 1'b0;

      // Fill the whole memory so every later read has a known expectation
      for (int i = 0; i < DEPTH; i++) xfer(1'b1, 2'b10, 32'(i * 4), 1'b1, 3'b010, $urandom);

      xfer(1'b1, 2'b10, 32'h00, 1'b1, 3'b010, 32'h44667255);
      xfer(1'b1, 2'b10, 32'h00, 1'b0, 3'b010, 32'h0);

      xfer(1'b1, 2'b10, 32'h04, 1'b1, 3'b010, 32'h0);
      xfer(1'b1, 2'b10, 32'h04, 1'b1, 3'b000, 32'h00000011);
      xfer(1'b1, 2'b10, 32'h05, 1'b1, 3'b000, 32'h00002200);
      xfer(1'b1, 2'b10, 32'h06, 1'b1, 3'b000, 32'h00330000);
      xfer(1'b1, 2'b10, 32'h07, 1'b1, 3'b000, 32'h44000000);
      xfer(1'b1, 2'b10, 32'h04, 1'b0, 3'b010, 32'h0);
      idle_bus();

      xfer(1'b1, 2'b10, 32'h02, 1'b0, 3'b010, 32'h0);
      xfer(1'b1, 2'b10, 32'(DEPTH * 4), 1'b0, 3'b010, 32'h0);
      xfer(1'b1, 2'b10, 32'(DEPTH * 4), 1'b1, 3'b000, 32'hdeadbeef);
      xfer(1'b1, 2'b10, 32'h00, 1'b1, 3'b010, 32'hcafef00d);   // bad hwdata for the preceding ERROR write must not land
      xfer(1'b1, 2'b10, 32'h09, 1'b1, 3'b001, 32'h12345678);
      xfer(1'b1, 2'b10, 32'h08, 1'b1, 3'b011, 32'h12345678);
      xfer(1'b1, 2'b10, 32'h00, 1'b0, 3'b010, 32'h0);
      xfer(1'b1, 2'b10, 32'h08, 1'b0, 3'b010, 32'h0);
      idle_bus();

      xfer(1'b1, 2'b10, 32'h10, 1'b1, 3'b010, 32'd1);
      xfer(1'b1, 2'b11, 32'h14, 1'b1, 3'b010, 32'd2);
      xfer(1'b1, 2'b11, 32'h18, 1'b1, 3'b010, 32'd3);
      xfer(1'b1, 2'b11, 32'h1C, 1'b1, 3'b010, 32'd4);
      xfer(1'b1, 2'b10, 32'h10, 1'b0, 3'b010, 32'h0);
      xfer(1'b1, 2'b11, 32'h14, 1'b0, 3'b010, 32'h0);
      xfer(1'b1, 2'b01, 32'h18, 1'b0, 3'b010, 32'h0);
      xfer(1'b1, 2'b01, 32'h18, 1'b0, 3'b010, 32'h0);
      xfer(1'b1, 2'b11, 32'h18, 1'b0, 3'b010, 32'h0);
      xfer(1'b1, 2'b11, 32'h1C, 1'b0, 3'b010, 32'h0);
      idle_bus();

      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         logic [2:0]  sz;
         sz = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
         a  = ($urandom_range(0, 7) == 0) ? 32'(DEPTH * 4 + $urandom_range(0, 15))
                                          : 32'($urandom_range(0, DEPTH * 4 - 1));
         if ($urandom_range(0, 1) == 1 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
         xfer($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), a, 1'($urandom_range(0, 1)), sz, $urandom);
      end
      idle_bus();

`ifdef AHB_SLV_WAIT_EN
      // Reset during the second wait cycle drops the write
      xfer(1'b1, 2'b10, 32'h20, 1'b1, 3'b010, 32'h5a5a5a5a, 1'b0);
      bus.hsel = 1'b0; bus.htrans = 2'b00;
      @(posedge hclk); #1;
      hreset = 1'b1;
      @(posedge hclk); #1;
      hreset = 1'b0;
      chk(bus.hreadyout == 1'b1, "midwait_reset_ready", 32'(bus.hreadyout), 32'd1);
      xfer(1'b1, 2'b10, 32'h20, 1'b0, 3'b010, 32'h0);
      idle_bus();
`endif

      guard = 0;
      while (sb.size() != 0 && guard < 50) begin
         @(posedge hclk); #1;
         guard++;
      end
      chk(sb.size() == 0, "scoreboard_drained", 32'(sb.size()), 32'd0);
      repeat (2) @(posedge hclk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
